uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
UART transmitter that consumes the control and data fields of the UART CSR block: UART_EN, TX_EN, BAUD_SEL, TX_IRQ_EN and TX_DATA. It returns TX_RDY and TX_DONE to the UART_STAT inputs. It contains its own baud-tick divider and serialises 8N1 frames, LSB first, onto the tx pin. The top level drives tx_start as a one-cycle pulse on any accepted UART_DATA write with wstrb[0] set.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- DIV_W, 16: width of the baud divider counter; must hold CLK_FREQ/4800.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- uart_en  in  1  UART_CTRL.UART_EN
- tx_en  in  1  UART_CTRL.TX_EN
- tx_irq_en  in  1  UART_CTRL.TX_IRQ_EN
- baud_sel  in  2  UART_CTRL.BAUD_SEL (00=4800, 01=9600, 10=57600, 11=115200)
- tx_data  in  8  UART_DATA.TX_DATA
- tx_start  in  1  one-cycle pulse requesting transmission of tx_data
- tx  out  1  serial line, idle high
- tx_rdy  out  1  to UART_STAT.TX_RDY; high when a new tx_start will be accepted
- tx_done  out  1  to UART_STAT.TX_DONE; one-cycle pulse at end of frame
- tx_irq  out  1  one-cycle interrupt pulse

Behaviour:
- Reset values: tx=1, tx_rdy=1, tx_done=0, tx_irq=0, state=IDLE, counters=0. All outputs are registered.
- Divisor DIV = CLK_FREQ/baud, integer floor, computed from parameters.
  - Defaults: 10416, 5208, 868, 434.
  - baud_sel is latched into the divisor at frame start. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, tx_rdy=1.
  - Accept condition: tx_start=1 with uart_en=1 and tx_en=1.
  - On accept: latch tx_data into an 8-bit shift register, latch DIV, clear the divider counter, go to START.
  - tx_start while either enable is low is dropped; no later effect.
- Timing, with the accept edge as cycle 0:
  - START: tx=0 for cycles 1..DIV. tx_rdy=0 from cycle 1.
  - DATA: bit i (i=0..7, LSB first) is driven for cycles 1+(i+1)*DIV .. (i+2)*DIV. A 3-bit bit counter advances on each divider wrap.
  - STOP: tx=1 for cycles 1+9*DIV .. 10*DIV.
  - Cycle 10*DIV+1: state=IDLE, tx_rdy=1, tx_done=1 for exactly one cycle.
  - tx_irq=1 in the same cycle if tx_irq_en=1 at that edge.
- Divider counter: counts 0..DIV-1 and wraps. The wrap is the bit-period boundary; no tick is generated outside a frame.
- tx_start while not IDLE: ignored. The shift register and the frame are unaffected, with no queueing. A tx_start arriving in the same cycle that tx_done is driven is ignored; it is accepted from the next cycle.
- Abort: uart_en or tx_en low in any non-IDLE state aborts.
  - Next cycle: state=IDLE, tx=1, tx_rdy=1.
  - No tx_done and no tx_irq are produced.
- rst mid-frame: immediate return to reset values on the next edge. The line goes high, possibly producing a truncated frame; this is acceptable.
- tx_data changing after accept does not alter the frame in flight.

Test Plan:
All scenarios use CLK_FREQ=1152000, giving DIV=240/120/20/10 for baud_sel=00/01/10/11.
1. baud_sel=11, enables=1, tx_data=0xA5, pulse tx_start.
   - tx=0 for cycles 1..10.
   - Bits 1,0,1,0,0,1,0,1 in 10-cycle slots.
   - Stop high for cycles 91..100.
   - tx_done and tx_rdy high at cycle 101.
2. baud_sel=00, tx_data=0x00 -> tx low for cycles 1..2160, then high for 2161..2400; tx_done at cycle 2401.
3. During the frame of scenario 1:
   - At cycle 30, drive tx_start with tx_data=0xFF and set baud_sel=00 -> frame still 0xA5 at 10-cycle bits, no second frame.
   - Then pulse tx_start in the tx_done cycle -> ignored.
   - Pulse tx_start at the next cycle -> new frame starts.
4. tx_en=0 with tx_start pulse -> tx stays 1, tx_rdy stays 1. Then start with tx_en=1 and drop uart_en at cycle 45 -> tx=1 and tx_rdy=1 at cycle 46, no tx_done or tx_irq.
5. tx_irq_en=1 with baud_sel=10, tx_data=0x3C -> tx_irq and tx_done coincide at cycle 201. Repeat with tx_irq_en=0 -> tx_done at 201, tx_irq stays 0.
6. Assert rst at cycle 50 of a frame -> next cycle tx=1, tx_rdy=1, tx_done=0. A start after rst is released transmits a full, correct frame.

Source files
------------

// File: rtl/uart_tx_core_if.sv
// Control/status bundle between the UART CSR block and the transmitter core.
// The CSR side drives the fields and the start pulse; the core returns line and status.
interface uart_tx_core_if;
    logic       uart_en;
    logic       tx_en;
    logic       tx_irq_en;
    logic [1:0] baud_sel;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx;
    logic       tx_rdy;
    logic       tx_done;
    logic       tx_irq;

    modport master (
        output uart_en, tx_en, tx_irq_en, baud_sel, tx_data, tx_start,
        input  tx, tx_rdy, tx_done, tx_irq
    );

    modport slave (
        input  uart_en, tx_en, tx_irq_en, baud_sel, tx_data, tx_start,
        output tx, tx_rdy, tx_done, tx_irq
    );
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with an internal baud divider, LSB first, idle-high line.
// The divisor is captured at frame start; dropping either enable aborts silently.
module uart_tx_core #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned DIV_W    = 16
) (
    input logic           clk,
    input logic           rst,
    uart_tx_core_if.slave bus_io
);

    localparam logic [DIV_W-1:0] Div4800   = DIV_W'(CLK_FREQ / 4800);
    localparam logic [DIV_W-1:0] Div9600   = DIV_W'(CLK_FREQ / 9600);
    localparam logic [DIV_W-1:0] Div57600  = DIV_W'(CLK_FREQ / 57600);
    localparam logic [DIV_W-1:0] Div115200 = DIV_W'(CLK_FREQ / 115200);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             rdy_q;
    logic             done_q;
    logic             irq_q;

    logic [DIV_W-1:0] div_sel;
    logic             enabled;
    logic             wrap;

    always_comb begin
        div_sel = Div4800;
        case (bus_io.baud_sel)
            2'b00:   div_sel = Div4800;
            2'b01:   div_sel = Div9600;
            2'b10:   div_sel = Div57600;
            default: div_sel = Div115200;
        endcase
    end

    assign enabled = bus_io.uart_en & bus_io.tx_en;
    assign wrap    = (cnt_q == div_q - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            irq_q  <= 1'b0;
            if (state_q != StIdle && !enabled) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                tx_q    <= 1'b1;
                rdy_q   <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        // A start landing in the tx_done cycle is deliberately dropped.
                        if (bus_io.tx_start && enabled && !done_q) begin
                            shift_q <= bus_io.tx_data;
                            div_q   <= div_sel;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            tx_q    <= 1'b0;
                            rdy_q   <= 1'b0;
                            state_q <= StStart;
                        end
                    end
                    StStart: begin
                        if (wrap) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            state_q <= StData;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    StData: begin
                        if (wrap) begin
                            cnt_q <= '0;
                            if (bit_q == 3'd7) begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end else begin
                                bit_q   <= bit_q + 3'd1;
                                tx_q    <= shift_q[0];
                                shift_q <= {1'b0, shift_q[7:1]};
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    StStop: begin
                        if (wrap) begin
                            cnt_q   <= '0;
                            rdy_q   <= 1'b1;
                            done_q  <= 1'b1;
                            irq_q   <= bus_io.tx_irq_en;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        tx_q    <= 1'b1;
                        rdy_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus_io.tx      = tx_q;
    assign bus_io.tx_rdy  = rdy_q;
    assign bus_io.tx_done = done_q;
    assign bus_io.tx_irq  = irq_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at CLK_FREQ=1152000 (DIV 240/120/20/10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_core;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    uart_tx_core_if bus ();

    uart_tx_core #(
        .CLK_FREQ(1152000),
        .DIV_W   (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse tx_start for one cycle; returns at the falling edge of cycle 1.
    task automatic kick(input logic [7:0] d, input logic [1:0] bs);
        bus.tx_data  = d;
        bus.baud_sel = bs;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Entered at cycle 1, returns at the tx_done cycle (10*div+1) after checking it.
    // poke_cyc>0 drives a stray start (data FF, baud 00) during that cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input int div,
                             input logic irq_exp, input int poke_cyc);
        int   bad;
        int   first;
        logic exp_tx;
        bad   = 0;
        first = 0;
        for (int c = 1; c <= 10 * div; c++) begin
            if (c <= div) exp_tx = 1'b0;
            else if (c <= 9 * div) exp_tx = d[(c - 1) / div - 1];
            else exp_tx = 1'b1;
            if (bus.tx !== exp_tx || bus.tx_rdy !== 1'b0 || bus.tx_done !== 1'b0 ||
                bus.tx_irq !== 1'b0) begin
                if (bad == 0) first = c;
                bad++;
            end
            if (c == poke_cyc) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'hFF;
                bus.baud_sel = 2'b00;
            end else if (poke_cyc != 0 && c == poke_cyc + 1) begin
                bus.tx_start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_wave_first_bad_cycle"}, first, 0);
        chk({tag, "_done"}, bus.tx_done, 1'b1);
        chk({tag, "_rdy"}, bus.tx_rdy, 1'b1);
        chk({tag, "_irq"}, bus.tx_irq, irq_exp);
        chk({tag, "_idle_tx"}, bus.tx, 1'b1);
    endtask

    initial begin
        int bad;
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.uart_en   = 1'b1;
        bus.tx_en     = 1'b1;
        bus.tx_irq_en = 1'b0;
        bus.baud_sel  = 2'b11;
        bus.tx_data   = 8'h00;
        bus.tx_start  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", bus.tx, 1'b1);
        chk("reset_rdy", bus.tx_rdy, 1'b1);
        chk("reset_done", bus.tx_done, 1'b0);
        chk("reset_irq", bus.tx_irq, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: A5 at DIV=10, then tx_done must fall after one cycle.
        kick(8'hA5, 2'b11);
        run_frame("s1", 8'hA5, 10, 1'b0, 0);
        @(negedge clk);
        chk("s1_done_one_cycle", bus.tx_done, 1'b0);
        chk("s1_rdy_after", bus.tx_rdy, 1'b1);

        // 2: all-zero byte at DIV=240.
        kick(8'h00, 2'b00);
        run_frame("s2", 8'h00, 240, 1'b0, 0);
        @(negedge clk);

        // 3: stray start mid-frame, start in done cycle ignored, next cycle accepted.
        kick(8'hA5, 2'b11);
        run_frame("s3", 8'hA5, 10, 1'b0, 30);
        bus.tx_data  = 8'h5A;
        bus.baud_sel = 2'b11;
        bus.tx_start = 1'b1;
        @(negedge clk);
        chk("s3_done_cycle_start_ignored_tx", bus.tx, 1'b1);
        chk("s3_done_cycle_start_ignored_rdy", bus.tx_rdy, 1'b1);
        @(negedge clk);
        bus.tx_start = 1'b0;
        run_frame("s3b", 8'h5A, 10, 1'b0, 0);
        @(negedge clk);

        // 4: start dropped with tx_en low, then abort via uart_en at cycle 45.
        bus.tx_en = 1'b0;
        kick(8'hA5, 2'b11);
        bad = 0;
        repeat (15) begin
            if (bus.tx !== 1'b1 || bus.tx_rdy !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("s4_disabled_start_dropped", bad, 0);
        bus.tx_en = 1'b1;
        kick(8'hA5, 2'b11);
        repeat (44) @(negedge clk);
        chk("s4_frame_running_c45", bus.tx, 1'b0);
        bus.uart_en = 1'b0;
        @(negedge clk);
        chk("s4_abort_tx", bus.tx, 1'b1);
        chk("s4_abort_rdy", bus.tx_rdy, 1'b1);
        chk("s4_abort_done", bus.tx_done, 1'b0);
        bus.uart_en   = 1'b1;
        bus.tx_irq_en = 1'b1;
        bad = 0;
        repeat (120) begin
            if (bus.tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_irq !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("s4_no_done_irq_after_abort", bad, 0);

        // 5: interrupt enable gating at DIV=20.
        bus.tx_irq_en = 1'b1;
        kick(8'h3C, 2'b10);
        run_frame("s5_irq_on", 8'h3C, 20, 1'b1, 0);
        @(negedge clk);
        chk("s5_irq_one_cycle", bus.tx_irq, 1'b0);
        bus.tx_irq_en = 1'b0;
        kick(8'h3C, 2'b10);
        run_frame("s5_irq_off", 8'h3C, 20, 1'b0, 0);
        @(negedge clk);

        // 6: synchronous reset at cycle 50, then a clean frame.
        kick(8'hC3, 2'b11);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_tx", bus.tx, 1'b1);
        chk("s6_rst_rdy", bus.tx_rdy, 1'b1);
        chk("s6_rst_done", bus.tx_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        kick(8'h96, 2'b11);
        run_frame("s6_after_rst", 8'h96, 10, 1'b0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
